// File: rtl/c128_bus_pkg.sv
// rtl/c128_bus_pkg.sv - shared states, owner encodings and parameter ranges for the bus arbiter
package c128_bus_pkg;

    typedef enum logic [2:0] {
        ST_Z80_RUN  = 3'd0,
        ST_Z80_STOP = 3'd1,
        ST_M85_RUN  = 3'd2,
        ST_M85_STOP = 3'd3,
        ST_HANDOFF  = 3'd4,
        ST_VIC_OWN  = 3'd5
    } bus_state_t;

    typedef enum logic {
        CPU_Z80  = 1'b0,
        CPU_8502 = 1'b1
    } cpu_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_Z80  = 2'b01;
    localparam logic [1:0] OWN_8502 = 2'b10;
    localparam logic [1:0] OWN_VIC  = 2'b11;

    localparam int DEAD_CYCLES_MIN  = 1;
    localparam int DEAD_CYCLES_MAX  = 15;
    localparam int STOP_TIMEOUT_MIN = 1;
    localparam int STOP_TIMEOUT_MAX = 255;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/bus_stop_timer.sv
// rtl/bus_stop_timer.sv - loadable down-counter with a done flag at zero
module bus_stop_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/c128_bus_arbiter.sv
// rtl/c128_bus_arbiter.sv - Z80 / 8502 / VIC DMA bus ownership sequencer
module c128_bus_arbiter
    import c128_bus_pkg::*;
#(
    parameter int DEAD_CYCLES  = 2,
    parameter int STOP_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       cpu_sel,
    input  logic       z80_busack,
    input  logic       m85_rw,
    input  logic       vic_req,
    output logic       z80_busreq,
    output logic       m85_rdy,
    output logic       vic_grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       err
);

    // Out-of-range parameters are clamped so the counters always see a legal load.
    localparam int DEAD_EFF = (DEAD_CYCLES < DEAD_CYCLES_MIN) ? DEAD_CYCLES_MIN :
                              (DEAD_CYCLES > DEAD_CYCLES_MAX) ? DEAD_CYCLES_MAX : DEAD_CYCLES;
    localparam int STOP_EFF = (STOP_TIMEOUT < STOP_TIMEOUT_MIN) ? STOP_TIMEOUT_MIN :
                              (STOP_TIMEOUT > STOP_TIMEOUT_MAX) ? STOP_TIMEOUT_MAX : STOP_TIMEOUT;

    // HANDOFF spends one entry cycle plus DEAD_EFF counted cycles; the stop timer
    // fires at the edge closing the STOP_EFF-th stop cycle.
    localparam logic [TIMER_W-1:0] DEAD_LOAD = TIMER_W'(DEAD_EFF);
    localparam logic [TIMER_W-1:0] STOP_LOAD = TIMER_W'(STOP_EFF - 1);

    bus_state_t state_q, state_d;
    cpu_t       resume_q, resume_d;
    cpu_t       target;
    logic       z80_busreq_d, m85_rdy_d, vic_grant_d, busy_d, err_d;
    logic [1:0] owner_d;
    logic       stop_load, stop_dec, stop_done;
    logic       dead_load, dead_dec, dead_done;

    bus_stop_timer #(.WIDTH(TIMER_W)) u_stop_timer (
        .clk        (clk),
        .reset_in   (reset_in),
        .load       (stop_load),
        .load_value (STOP_LOAD),
        .dec        (stop_dec),
        .done       (stop_done)
    );

    bus_stop_timer #(.WIDTH(TIMER_W)) u_dead_timer (
        .clk        (clk),
        .reset_in   (reset_in),
        .load       (dead_load),
        .load_value (DEAD_LOAD),
        .dec        (dead_dec),
        .done       (dead_done)
    );

    // Exit target: the remembered CPU if the MMU still selects it, otherwise the latest selection.
    assign target = (resume_q == cpu_t'(cpu_sel)) ? resume_q : cpu_t'(cpu_sel);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        z80_busreq_d = z80_busreq;
        m85_rdy_d    = m85_rdy;
        vic_grant_d  = vic_grant;
        owner_d      = owner;
        busy_d       = busy;
        err_d        = err;
        stop_load    = 1'b0;
        stop_dec     = 1'b0;
        dead_load    = 1'b0;
        dead_dec     = 1'b0;

        case (state_q)
            ST_Z80_RUN: begin
                if (vic_req || cpu_sel) begin
                    state_d      = ST_Z80_STOP;
                    resume_d     = vic_req ? CPU_Z80 : CPU_8502;
                    z80_busreq_d = 1'b1;
                    busy_d       = 1'b1;
                    stop_load    = 1'b1;
                end
            end
            ST_Z80_STOP: begin
                if (z80_busack || stop_done) begin
                    err_d     = err | ~z80_busack;
                    state_d   = ST_HANDOFF;
                    owner_d   = OWN_NONE;
                    dead_load = 1'b1;
                end else begin
                    stop_dec = 1'b1;
                end
            end
            ST_M85_RUN: begin
                if (vic_req || !cpu_sel) begin
                    state_d   = ST_M85_STOP;
                    resume_d  = vic_req ? CPU_8502 : CPU_Z80;
                    m85_rdy_d = 1'b0;
                    busy_d    = 1'b1;
                    stop_load = 1'b1;
                end
            end
            ST_M85_STOP: begin
                // RDY only halts the 8502 on a read cycle, so writes must be waited out.
                if (m85_rw || stop_done) begin
                    err_d     = err | ~m85_rw;
                    state_d   = ST_HANDOFF;
                    owner_d   = OWN_NONE;
                    dead_load = 1'b1;
                end else begin
                    stop_dec = 1'b1;
                end
            end
            ST_HANDOFF: begin
                if (!dead_done) begin
                    dead_dec = 1'b1;
                end else if (vic_req) begin
                    state_d     = ST_VIC_OWN;
                    vic_grant_d = 1'b1;
                    owner_d     = OWN_VIC;
                end else if (target == CPU_Z80) begin
                    state_d      = ST_Z80_RUN;
                    z80_busreq_d = 1'b0;
                    owner_d      = OWN_Z80;
                    busy_d       = 1'b0;
                end else begin
                    state_d   = ST_M85_RUN;
                    m85_rdy_d = 1'b1;
                    owner_d   = OWN_8502;
                    busy_d    = 1'b0;
                end
            end
            ST_VIC_OWN: begin
                if (!vic_req) begin
                    state_d     = ST_HANDOFF;
                    vic_grant_d = 1'b0;
                    owner_d     = OWN_NONE;
                    dead_load   = 1'b1;
                end
            end
            default: begin
                state_d = ST_Z80_RUN;
            end
        endcase
    end

    // State, resume target and output registers.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q    <= ST_Z80_RUN;
            resume_q   <= CPU_Z80;
            z80_busreq <= 1'b0;
            m85_rdy    <= 1'b0;
            vic_grant  <= 1'b0;
            owner      <= OWN_Z80;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            z80_busreq <= z80_busreq_d;
            m85_rdy    <= m85_rdy_d;
            vic_grant  <= vic_grant_d;
            owner      <= owner_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_c128_bus_arbiter.sv
// tb/tb_c128_bus_arbiter.sv - scoreboard bench for the C128 bus arbiter
module tb_c128_bus_arbiter;

    localparam int DEAD = 2;
    localparam int TOUT = 8;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       cpu_sel = 1'b0;
    logic       z80_busack = 1'b0;
    logic       m85_rw = 1'b1;
    logic       vic_req = 1'b0;
    logic       z80_busreq, m85_rdy, vic_grant, busy, err;
    logic [1:0] owner;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb_q[$];

    c128_bus_arbiter #(.DEAD_CYCLES(DEAD), .STOP_TIMEOUT(TOUT)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .cpu_sel    (cpu_sel),
        .z80_busack (z80_busack),
        .m85_rw     (m85_rw),
        .vic_req    (vic_req),
        .z80_busreq (z80_busreq),
        .m85_rdy    (m85_rdy),
        .vic_grant  (vic_grant),
        .owner      (owner),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Packed {busreq, rdy, grant, owner[1:0], busy, err}
    function automatic logic [6:0] mk(input logic br, input logic rdy, input logic gr,
                                      input logic [1:0] own, input logic bsy, input logic er);
        return {br, rdy, gr, own, bsy, er};
    endfunction

    localparam logic [6:0] E_Z80RUN = 7'b0_0_0_01_0_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [6:0] obs;
        e   = sb_q.pop_front();
        obs = {z80_busreq, m85_rdy, vic_grant, owner, busy, err};
        n_cmp++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then compare.
    task automatic step(input string tag, input logic [6:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
        tick();
        check_pop();
    endtask

    initial begin
        logic ok;

        // Reset state
        step("reset0", E_Z80RUN);
        step("reset1", E_Z80RUN);
        reset_in = 1'b0;
        step("z80_idle", E_Z80RUN);

        // Z80 -> 8502, busack three cycles after busreq
        cpu_sel = 1'b1;
        step("z2m_stop", mk(1, 0, 0, 2'b01, 1, 0));
        step("z2m_wait1", mk(1, 0, 0, 2'b01, 1, 0));
        step("z2m_wait2", mk(1, 0, 0, 2'b01, 1, 0));
        z80_busack = 1'b1;
        step("z2m_ack", mk(1, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < DEAD; i++) step("z2m_dead", mk(1, 0, 0, 2'b00, 1, 0));
        step("z2m_release", mk(1, 1, 0, 2'b10, 0, 0));
        step("m85_hold", mk(1, 1, 0, 2'b10, 0, 0));

        // 8502 -> Z80 with a write burst holding off the stop
        cpu_sel = 1'b0;
        m85_rw = 1'b0;
        z80_busack = 1'b0;
        step("m2z_stop", mk(1, 0, 0, 2'b10, 1, 0));
        for (int i = 0; i < 3; i++) step("m2z_write", mk(1, 0, 0, 2'b10, 1, 0));
        m85_rw = 1'b1;
        step("m2z_read", mk(1, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < DEAD; i++) step("m2z_dead", mk(1, 0, 0, 2'b00, 1, 0));
        step("m2z_release", E_Z80RUN);

        // vic_req and cpu_sel together: VIC first, then the 8502
        vic_req = 1'b1;
        cpu_sel = 1'b1;
        step("vic_stop", mk(1, 0, 0, 2'b01, 1, 0));
        z80_busack = 1'b1;
        step("vic_ack", mk(1, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < DEAD; i++) step("vic_dead", mk(1, 0, 0, 2'b00, 1, 0));
        step("vic_grant", mk(1, 0, 1, 2'b11, 1, 0));
        step("vic_hold", mk(1, 0, 1, 2'b11, 1, 0));
        vic_req = 1'b0;
        step("vic_drop", mk(1, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < DEAD; i++) step("vic_dead2", mk(1, 0, 0, 2'b00, 1, 0));
        step("vic_to_m85", mk(1, 1, 0, 2'b10, 0, 0));

        // VIC from 8502, then reset in the middle of VIC_OWN
        vic_req = 1'b1;
        step("m_vic_stop", mk(1, 0, 0, 2'b10, 1, 0));
        step("m_vic_ack", mk(1, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < DEAD; i++) step("m_vic_dead", mk(1, 0, 0, 2'b00, 1, 0));
        step("m_vic_grant", mk(1, 0, 1, 2'b11, 1, 0));
        reset_in = 1'b1;
        step("rst_in_vic", E_Z80RUN);
        reset_in = 1'b0;
        vic_req = 1'b0;
        cpu_sel = 1'b0;
        z80_busack = 1'b0;
        step("post_rst", E_Z80RUN);

        // Stop timeout with busack held low
        cpu_sel = 1'b1;
        step("to_stop", mk(1, 0, 0, 2'b01, 1, 0));
        for (int i = 1; i < TOUT; i++) step("to_wait", mk(1, 0, 0, 2'b01, 1, 0));
        step("to_fire", mk(1, 0, 0, 2'b00, 1, 1));
        for (int i = 0; i < DEAD; i++) step("to_dead", mk(1, 0, 0, 2'b00, 1, 1));
        step("to_m85", mk(1, 1, 0, 2'b10, 0, 1));
        cpu_sel = 1'b0;
        step("to_sticky_stop", mk(1, 0, 0, 2'b10, 1, 1));
        step("to_sticky_ho", mk(1, 0, 0, 2'b00, 1, 1));
        reset_in = 1'b1;
        step("rst_in_handoff", E_Z80RUN);
        reset_in = 1'b0;
        step("err_cleared", E_Z80RUN);

        // Random traffic with structural invariants
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) cpu_sel = ~cpu_sel;
            if ($urandom_range(0, 23) == 0) vic_req = ~vic_req;
            z80_busack = z80_busreq & ($urandom_range(0, 3) != 0);
            m85_rw = ($urandom_range(0, 2) != 0);
            tick();
            ok = (!vic_grant || (z80_busreq && !m85_rdy && busy))
                 && (vic_grant == (owner == 2'b11))
                 && (!m85_rdy || (owner == 2'b10 && z80_busreq))
                 && (z80_busreq || (owner == 2'b01 && !m85_rdy && !vic_grant));
            n_cmp++;
            assert (ok === 1'b1) else begin
                n_fail++;
                $error("FAIL rand_invariant cycle=%0d observed=%b expected=consistent", i,
                       {z80_busreq, m85_rdy, vic_grant, owner, busy, err});
            end
        end

        reset_in = 1'b1;
        step("final_reset", E_Z80RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
